// File: rtl/packer_pkg.sv
// Shared types and sizing constants for the nibble packer.
package packer_pkg;

   // FILL issues reads, HOLD parks a full accumulator, DRAIN finishes a flush.
   typedef enum logic [1:0] {
      FILL  = 2'd0,
      HOLD  = 2'd1,
      DRAIN = 2'd2
   } packer_state_t;

   // Largest legal entries-per-word; the counter is sized so any legal NUM_NIB fits.
   localparam int NUM_NIB_MAX = 8;
   localparam int NIB_CNT_W   = $clog2(NUM_NIB_MAX + 1);

   // Width of the accepted-handshake counter (wraps naturally).
   localparam int WORD_CNT_W  = 8;

endpackage

// File: rtl/packer_out_stage.sv
// One-word output register with valid/ready, partial flag, handshake counter
// and, when PACKER_PARITY_EN is defined, a registered parity bit.
module packer_out_stage
   import packer_pkg::*;
#(
   parameter int WORD_W = 16
) (
   input  logic                  clk_b,
   input  logic                  rst,
   input  logic                  i_load,
   input  logic [WORD_W-1:0]     i_load_data,
   input  logic                  i_load_partial,
   input  logic                  i_ready,
   output logic                  o_valid,
   output logic [WORD_W-1:0]     o_data,
   output logic                  o_partial,
`ifdef PACKER_PARITY_EN
   output logic                  o_parity,
`endif
   output logic [WORD_CNT_W-1:0] o_count
);

   logic                  r_valid;
   logic [WORD_W-1:0]     r_data;
   logic                  r_partial;
   logic [WORD_CNT_W-1:0] r_count;

   // Load a new word (the producer only loads when empty or handing off),
   // otherwise drop valid once the consumer takes the word.
   always_ff @(posedge clk_b) begin
      if (rst) begin
         r_valid   <= 1'b0;
         r_data    <= '0;
         r_partial <= 1'b0;
         r_count   <= '0;
      end else begin
         if (i_load) begin
            r_valid   <= 1'b1;
            r_data    <= i_load_data;
            r_partial <= i_load_partial;
         end else if (i_ready) begin
            r_valid   <= 1'b0;
         end
         if (r_valid && i_ready) begin
            r_count <= r_count + 1'b1;
         end
      end
   end

`ifdef PACKER_PARITY_EN
   logic r_parity;

   // Parity travels with the word so it is always consistent with o_data.
   always_ff @(posedge clk_b) begin
      if (rst) begin
         r_parity <= 1'b0;
      end else if (i_load) begin
         r_parity <= ^i_load_data;
      end
   end

   assign o_parity = r_parity;
`endif

   assign o_valid   = r_valid;
   assign o_data    = r_data;
   assign o_partial = r_partial;
   assign o_count   = r_count;

endmodule

// File: rtl/fifo_nibble_packer.sv
// Read-side FIFO consumer: packs NUM_NIB entries into one word, with flush
// of zero-padded partial words. Optional parity output: PACKER_PARITY_EN.
module fifo_nibble_packer
   import packer_pkg::*;
#(
   parameter int DATA_W    = 4,
   parameter int NUM_NIB   = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic                      clk_b,
   input  logic                      rst,
   input  logic                      fifo_empty_i,
   input  logic [DATA_W-1:0]         rd_data_i,
   output logic                      rd_en_o,
   input  logic                      flush_i,
   input  logic                      word_ready_i,
   output logic                      word_valid_o,
   output logic [DATA_W*NUM_NIB-1:0] word_data_o,
   output logic                      word_partial_o,
`ifdef PACKER_PARITY_EN
   output logic                      word_parity_o,
`endif
   output logic [WORD_CNT_W-1:0]     word_count_o
);

   localparam int WORD_W = DATA_W * NUM_NIB;

   packer_state_t          r_state, w_state_next;
   logic [NIB_CNT_W-1:0]   r_nib_cnt;
   logic                   r_inflight;
   logic [WORD_W-1:0]      r_acc;

   logic [NIB_CNT_W-1:0]   w_cnt_after;
   logic [NIB_CNT_W-1:0]   w_pos;
   logic [WORD_W-1:0]      w_acc_after;
   logic                   w_full;
   logic                   w_out_valid;
   logic                   w_out_free;
   logic                   w_slot_free;
   logic                   w_load;
   logic                   w_load_partial;
   logic                   w_clear;

   // Count and accumulator as they will stand after this cycle's capture.
   assign w_cnt_after = r_nib_cnt + NIB_CNT_W'(r_inflight);
   assign w_full      = (w_cnt_after == NIB_CNT_W'(NUM_NIB));
   assign w_pos       = MSB_FIRST ? (NIB_CNT_W'(NUM_NIB - 1) - r_nib_cnt) : r_nib_cnt;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_NIB; gi++) begin : g_slot
         assign w_acc_after[gi*DATA_W +: DATA_W] =
            (r_inflight && (w_pos == NIB_CNT_W'(gi))) ? rd_data_i
                                                      : r_acc[gi*DATA_W +: DATA_W];
      end
   endgenerate

   // A read may issue if its entry has a slot, or if the entry in flight
   // completes the word and that word can leave at the same edge.
   assign w_out_free  = ~w_out_valid | word_ready_i;
   assign w_slot_free = (w_cnt_after < NIB_CNT_W'(NUM_NIB)) |
                        (r_inflight & w_full & w_out_free);
   assign rd_en_o     = ~rst & ~fifo_empty_i & (r_state == FILL) & w_slot_free;

   // Next-state and word-load decisions.
   always_comb begin
      w_state_next   = r_state;
      w_load         = 1'b0;
      w_load_partial = 1'b0;
      w_clear        = 1'b0;
      case (r_state)
         FILL: begin
            if (r_inflight && w_full) begin
               if (w_out_free) begin
                  w_load  = 1'b1;
                  w_clear = 1'b1;
                  if (flush_i) w_state_next = DRAIN;
               end else begin
                  w_state_next = HOLD;
               end
            end else if (flush_i) begin
               w_state_next = DRAIN;
            end
         end
         HOLD: begin
            if (w_out_free) begin
               w_load       = 1'b1;
               w_clear      = 1'b1;
               w_state_next = FILL;
            end
         end
         DRAIN: begin
            if (r_inflight && w_full) begin
               // Late entry filled the word: it leaves as a normal full word.
               if (w_out_free) begin
                  w_load       = 1'b1;
                  w_clear      = 1'b1;
                  w_state_next = FILL;
               end else begin
                  w_state_next = HOLD;
               end
            end else if (!r_inflight) begin
               if (r_nib_cnt == '0) begin
                  w_state_next = FILL;
               end else if (w_out_free) begin
                  w_load         = 1'b1;
                  w_load_partial = 1'b1;
                  w_clear        = 1'b1;
                  w_state_next   = FILL;
               end
            end
         end
         default: w_state_next = FILL;
      endcase
   end

   // State, accumulator and in-flight tracking; reset discards any partial word.
   always_ff @(posedge clk_b) begin
      if (rst) begin
         r_state    <= FILL;
         r_nib_cnt  <= '0;
         r_inflight <= 1'b0;
         r_acc      <= '0;
      end else begin
         r_state    <= w_state_next;
         r_inflight <= rd_en_o;
         r_nib_cnt  <= w_clear ? '0 : w_cnt_after;
         r_acc      <= w_clear ? '0 : w_acc_after;
      end
   end

   packer_out_stage #(
      .WORD_W (WORD_W)
   ) u_out_stage (
      .clk_b          (clk_b),
      .rst            (rst),
      .i_load         (w_load),
      .i_load_data    (w_acc_after),
      .i_load_partial (w_load_partial),
      .i_ready        (word_ready_i),
      .o_valid        (w_out_valid),
      .o_data         (word_data_o),
      .o_partial      (word_partial_o),
`ifdef PACKER_PARITY_EN
      .o_parity       (word_parity_o),
`endif
      .o_count        (word_count_o)
   );

   assign word_valid_o = w_out_valid;

endmodule

// File: tb/tb_fifo_nibble_packer.sv
// Randomized bench for fifo_nibble_packer: two instances (MSB-first and
// LSB-first) share one FIFO model; a grouping model predicts every word.
module tb_fifo_nibble_packer;

   localparam int DATA_W  = 4;
   localparam int NUM_NIB = 4;
   localparam int WORD_W  = DATA_W * NUM_NIB;

   logic              clk_b = 1'b0;
   logic              rst = 1'b1;
   logic              fifo_empty_i = 1'b1;
   logic [DATA_W-1:0] rd_data_i = '0;
   logic              flush_i = 1'b0;
   logic              word_ready_i = 1'b1;

   logic              rd_en_a, rd_en_b;
   logic              valid_a, valid_b;
   logic [WORD_W-1:0] data_a, data_b;
   logic              partial_a, partial_b;
   logic [7:0]        count_a, count_b;
`ifdef PACKER_PARITY_EN
   logic              par_a, par_b;
`endif

   always #5 clk_b = ~clk_b;

   fifo_nibble_packer #(.DATA_W(DATA_W), .NUM_NIB(NUM_NIB), .MSB_FIRST(1'b1)) u_dut_msb (
      .clk_b          (clk_b),
      .rst            (rst),
      .fifo_empty_i   (fifo_empty_i),
      .rd_data_i      (rd_data_i),
      .rd_en_o        (rd_en_a),
      .flush_i        (flush_i),
      .word_ready_i   (word_ready_i),
      .word_valid_o   (valid_a),
      .word_data_o    (data_a),
      .word_partial_o (partial_a),
`ifdef PACKER_PARITY_EN
      .word_parity_o  (par_a),
`endif
      .word_count_o   (count_a)
   );

   fifo_nibble_packer #(.DATA_W(DATA_W), .NUM_NIB(NUM_NIB), .MSB_FIRST(1'b0)) u_dut_lsb (
      .clk_b          (clk_b),
      .rst            (rst),
      .fifo_empty_i   (fifo_empty_i),
      .rd_data_i      (rd_data_i),
      .rd_en_o        (rd_en_b),
      .flush_i        (flush_i),
      .word_ready_i   (word_ready_i),
      .word_valid_o   (valid_b),
      .word_data_o    (data_b),
      .word_partial_o (partial_b),
`ifdef PACKER_PARITY_EN
      .word_parity_o  (par_b),
`endif
      .word_count_o   (count_b)
   );

   typedef struct {
      logic [WORD_W-1:0] msb;
      logic [WORD_W-1:0] lsb;
      logic              partial;
   } exp_t;

   logic [DATA_W-1:0] fifo_q[$];   // FIFO contents
   logic [DATA_W-1:0] grp[$];      // entries of the word being assembled
   exp_t              exp_q[$];    // words expected, in order

   int n_checks = 0;
   int n_fail   = 0;
   int cyc = 0, n_reads = 0, last_rd_cyc = 0;
   int run_len = 0, max_run = 0;
   int hs_count = 0, emitted = 0;
   logic obs_valid = 1'b0;
   logic [WORD_W-1:0] last_hs_a = '0, last_hs_b = '0;
   logic last_hs_partial = 1'b0;
   logic stall_prev = 1'b0;
   logic [WORD_W-1:0] stall_data = '0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Close the current group into an expected word.
   task automatic emit(input logic partial);
      exp_t e;
      e.msb = '0;
      e.lsb = '0;
      e.partial = partial;
      for (int i = 0; i < grp.size(); i++) begin
         e.msb = e.msb | (WORD_W'(grp[i]) << ((NUM_NIB - 1 - i) * DATA_W));
         e.lsb = e.lsb | (WORD_W'(grp[i]) << (i * DATA_W));
      end
      exp_q.push_back(e);
      emitted++;
      grp.delete();
   endtask

   task automatic push_entry(input logic [DATA_W-1:0] v);
      fifo_q.push_back(v);
      grp.push_back(v);
      if (grp.size() == NUM_NIB) emit(1'b0);
      fifo_empty_i = 1'b0;
   endtask

   // One clock: check outputs mid-cycle, then update FIFO outputs after the edge.
   task automatic step();
      logic acc_rd;
      exp_t e;
      @(negedge clk_b);
      cyc++;
      acc_rd    = rd_en_a && !fifo_empty_i;
      obs_valid = valid_a;
      if (fifo_empty_i) begin
         check("rd_en_msb_while_empty", rd_en_a, 1'b0);
         check("rd_en_lsb_while_empty", rd_en_b, 1'b0);
      end
      check("word_count_msb", count_a, 8'(hs_count));
      check("word_count_lsb", count_b, 8'(hs_count));
      if (stall_prev) begin
         check("stall_valid", valid_a, 1'b1);
         check("stall_data", data_a, stall_data);
      end
      if (valid_a && word_ready_i) begin
         if (exp_q.size() == 0) begin
            check("spurious_word", valid_a, 1'b0);
         end else begin
            e = exp_q.pop_front();
            $display("word %0d: msb_first=%h lsb_first=%h partial=%0b",
                     hs_count, data_a, data_b, partial_a);
            check("word_data_msb", data_a, e.msb);
            check("word_valid_lsb", valid_b, 1'b1);
            check("word_data_lsb", data_b, e.lsb);
            check("word_partial", partial_a, e.partial);
`ifdef PACKER_PARITY_EN
            check("word_parity", par_a, ^e.msb);
            check("word_parity_lsb", par_b, ^e.lsb);
`endif
         end
         hs_count++;
         last_hs_a       = data_a;
         last_hs_b       = data_b;
         last_hs_partial = partial_a;
      end
      stall_prev = valid_a && !word_ready_i;
      stall_data = data_a;
      if (rd_en_a) begin
         run_len++;
         if (run_len > max_run) max_run = run_len;
      end else begin
         run_len = 0;
      end
      if (acc_rd) begin
         n_reads++;
         last_rd_cyc = cyc;
      end
      @(posedge clk_b);
      #1;
      if (acc_rd) rd_data_i = fifo_q.pop_front();
      else        rd_data_i = DATA_W'($urandom);
      fifo_empty_i = (fifo_q.size() == 0);
   endtask

   task automatic rstep();
      word_ready_i = ($urandom_range(0, 3) != 0);
      step();
   endtask

   task automatic do_flush();
      flush_i = 1'b1;
      if (grp.size() > 0) emit(1'b1);
      step();
      flush_i = 1'b0;
   endtask

   task automatic wait_words(input int budget);
      for (int i = 0; i < budget && exp_q.size() > 0; i++) step();
   endtask

   int base_hs, base_rd;

   initial begin
      // Reset with data already waiting in the FIFO.
      push_entry(4'h1); push_entry(4'h2); push_entry(4'h3); push_entry(4'h4);
      step();
      check("reset_rd_en", rd_en_a, 1'b0);
      check("reset_valid", valid_a, 1'b0);
      check("reset_data", data_a, '0);
      check("reset_partial", partial_a, 1'b0);
      check("reset_count", count_a, 8'd0);
      step();
      rst = 1'b0;

      // Basic word 1,2,3,4 and its latency.
      for (int i = 0; i < 20; i++) begin
         step();
         if (obs_valid) break;
      end
      check("t1_valid_seen", obs_valid, 1'b1);
      check("t1_latency", cyc - last_rd_cyc, 2);
      check("t1_data_msb", last_hs_a, 16'h1234);
      check("t2_data_lsb", last_hs_b, 16'h4321);
      check("t1_partial", last_hs_partial, 1'b0);
      check("t1_count", count_a, 8'd1);

      // 16 entries back-to-back.
      base_hs = hs_count; max_run = 0; run_len = 0;
      for (int i = 0; i < 16; i++) push_entry(DATA_W'($urandom));
      for (int i = 0; i < 24; i++) step();
      check("t3_rd_en_run", max_run, 16);
      check("t3_words", hs_count - base_hs, 4);
      check("t3_count", count_a, 8'd5);

      // Back-pressure: 12 entries with ready low.
      word_ready_i = 1'b0;
      base_hs = hs_count; base_rd = n_reads;
      for (int i = 0; i < 12; i++) push_entry(DATA_W'($urandom));
      for (int i = 0; i < 15; i++) step();
      check("t4_reads_in_hold", n_reads - base_rd, 8);
      check("t4_no_handshake", hs_count - base_hs, 0);
      word_ready_i = 1'b1;
      wait_words(40);
      check("t4_reads_total", n_reads - base_rd, 12);
      check("t4_words", hs_count - base_hs, 3);

      // Flush of a partial word, then a flush with nothing captured.
      push_entry(4'hA); push_entry(4'hB);
      for (int i = 0; i < 4; i++) step();
      do_flush();
      wait_words(20);
      check("t5_flush_msb", last_hs_a, 16'hAB00);
      check("t5_flush_lsb", last_hs_b, 16'h00BA);
      check("t5_flush_partial", last_hs_partial, 1'b1);
      base_hs = hs_count;
      do_flush();
      for (int i = 0; i < 8; i++) step();
      check("t5_empty_flush", hs_count - base_hs, 0);

      // Reset in the middle of a word.
      push_entry(4'h1); push_entry(4'h2);
      for (int i = 0; i < 4; i++) step();
      rst = 1'b1;
      step();
      check("t6_rst_rd_en", rd_en_a, 1'b0);
      rst = 1'b0;
      grp.delete();
      exp_q.delete();
      hs_count = 0; emitted = 0; stall_prev = 1'b0;
      check("t6_valid", valid_a, 1'b0);
      check("t6_data", data_a, '0);
      check("t6_partial", partial_a, 1'b0);
      check("t6_count", count_a, 8'd0);
      push_entry(4'h5); push_entry(4'h6); push_entry(4'h7); push_entry(4'h8);
      wait_words(20);
      check("t6_data_after", last_hs_a, 16'h5678);
      check("t6_partial_after", last_hs_partial, 1'b0);

      // Randomized traffic with random back-pressure and occasional flushes.
      for (int seg = 0; seg < 40; seg++) begin
         int n;
         n = $urandom_range(0, 9);
         for (int i = 0; i < n; i++) push_entry(DATA_W'($urandom));
         for (int i = 0; i < 200 && fifo_q.size() > 0; i++) rstep();
         check("rand_fifo_drained", fifo_q.size(), 0);
         rstep();
         rstep();
         if ($urandom_range(0, 1) == 1) do_flush();
      end
      word_ready_i = 1'b1;
      wait_words(60);
      check("final_word_total", hs_count, emitted);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
